// File: rtl/alt_vipvfr120_prc_read_cmd_scheduler.sv
// Frame read command sequencer: walks lines x words with a line stride and
// issues Avalon read bursts of at most MAX_BURST words to the prc read master.
module alt_vipvfr120_prc_read_cmd_scheduler #(
  parameter int ADDR_WIDTH                     = 32,
  parameter int MAX_BURST_LENGTH_REQUIREDWIDTH = 11,
  parameter int MAX_BURST                      = 32,
  parameter int WORD_BYTES                     = 4,
  parameter int WORDS_WIDTH                    = 16,
  parameter int LINES_WIDTH                    = 12
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      go,
  input  logic                                      abort,
  input  logic [ADDR_WIDTH-1:0]                     base_addr,
  input  logic [WORDS_WIDTH-1:0]                    words_per_line,
  input  logic [LINES_WIDTH-1:0]                    num_lines,
  input  logic [ADDR_WIDTH-1:0]                     line_stride,
  input  logic                                      stall,
  output logic                                      cmd,
  output logic [ADDR_WIDTH-1:0]                     cmd_addr,
  output logic                                      cmd_write_instead_of_read,
  output logic                                      cmd_burst_instead_of_single_op,
  output logic [MAX_BURST_LENGTH_REQUIREDWIDTH-1:0] cmd_length_of_burst,
  output logic                                      line_end,
  output logic                                      busy,
  output logic                                      done
);

  localparam int LW       = MAX_BURST_LENGTH_REQUIREDWIDTH;
  localparam int WB_SHIFT = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_line_addr;
  logic [ADDR_WIDTH-1:0]  r_cur_addr;
  logic [ADDR_WIDTH-1:0]  r_stride;
  logic [WORDS_WIDTH-1:0] r_words;
  logic [WORDS_WIDTH-1:0] r_rem;
  logic [LINES_WIDTH-1:0] r_num_lines;
  logic [LINES_WIDTH-1:0] r_line_cnt;
  logic                   r_cmd;
  logic [ADDR_WIDTH-1:0]  r_cmd_addr;
  logic [LW-1:0]          r_len;
  logic                   r_burst;
  logic                   r_line_end;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_accept;
  logic [WORDS_WIDTH-1:0] w_rem_nxt;
  logic [ADDR_WIDTH-1:0]  w_cur_nxt;
  logic [ADDR_WIDTH-1:0]  w_line_addr_nxt;
  logic [LINES_WIDTH-1:0] w_line_cnt_nxt;
  logic [LW-1:0]          w_first_len;
  logic [LW-1:0]          w_line_len;
  logic [LW-1:0]          w_rem_len;

  function automatic logic [LW-1:0] clamp_len(input logic [WORDS_WIDTH-1:0] rem);
    if (rem > WORDS_WIDTH'(MAX_BURST)) begin
      return LW'(MAX_BURST);
    end else begin
      return LW'(rem);
    end
  endfunction

  // Next-command arithmetic shared by every accept path
  always_comb begin
    w_accept        = r_cmd & ~stall;
    w_rem_nxt       = r_rem - WORDS_WIDTH'(r_len);
    w_cur_nxt       = r_cur_addr + (ADDR_WIDTH'(r_len) << WB_SHIFT);
    w_line_addr_nxt = r_line_addr + r_stride;
    w_line_cnt_nxt  = r_line_cnt + LINES_WIDTH'(1);
    w_first_len     = clamp_len(words_per_line);
    w_line_len      = clamp_len(r_words);
    w_rem_len       = clamp_len(w_rem_nxt);
  end

  // Frame walker FSM with registered command and status outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_line_addr <= '0;
      r_cur_addr  <= '0;
      r_stride    <= '0;
      r_words     <= '0;
      r_rem       <= '0;
      r_num_lines <= '0;
      r_line_cnt  <= '0;
      r_cmd       <= 1'b0;
      r_cmd_addr  <= '0;
      r_len       <= '0;
      r_burst     <= 1'b0;
      r_line_end  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_line_end <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (go && !r_done) begin
            r_busy <= 1'b1;
            if ((words_per_line != '0) && (num_lines != '0)) begin
              r_words     <= words_per_line;
              r_num_lines <= num_lines;
              r_stride    <= line_stride;
              r_line_addr <= base_addr;
              r_cur_addr  <= base_addr;
              r_rem       <= words_per_line;
              r_line_cnt  <= '0;
              r_cmd       <= 1'b1;
              r_cmd_addr  <= base_addr;
              r_len       <= w_first_len;
              r_burst     <= (w_first_len > LW'(1));
              r_state     <= S_ISSUE;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_ISSUE: begin
          if (w_accept) begin
            r_cur_addr <= w_cur_nxt;
            r_rem      <= w_rem_nxt;
            if (w_rem_nxt == '0) begin
              r_line_end <= 1'b1;
              r_line_cnt <= w_line_cnt_nxt;
              if ((w_line_cnt_nxt == r_num_lines) || abort) begin
                r_cmd   <= 1'b0;
                r_len   <= '0;
                r_burst <= 1'b0;
                r_state <= S_DONE;
              end else begin
                r_line_addr <= w_line_addr_nxt;
                r_cur_addr  <= w_line_addr_nxt;
                r_rem       <= r_words;
                r_cmd_addr  <= w_line_addr_nxt;
                r_len       <= w_line_len;
                r_burst     <= (w_line_len > LW'(1));
              end
            end else if (abort) begin
              r_cmd   <= 1'b0;
              r_len   <= '0;
              r_burst <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_cmd_addr <= w_cur_nxt;
              r_len      <= w_rem_len;
              r_burst    <= (w_rem_len > LW'(1));
            end
          end else if (abort) begin
            // held command was never accepted, so it can simply be withdrawn
            r_cmd   <= 1'b0;
            r_len   <= '0;
            r_burst <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_cmd   <= 1'b0;
          r_done  <= 1'b1;
          r_busy  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_cmd   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd                            = r_cmd;
  assign cmd_addr                       = r_cmd_addr;
  assign cmd_write_instead_of_read      = 1'b0;
  assign cmd_burst_instead_of_single_op = r_burst;
  assign cmd_length_of_burst            = r_len;
  assign line_end                       = r_line_end;
  assign busy                           = r_busy;
  assign done                           = r_done;

endmodule

// File: tb/tb_alt_vipvfr120_prc_read_cmd_scheduler.sv
// Directed self-checking bench for the frame read command scheduler.
module tb_alt_vipvfr120_prc_read_cmd_scheduler;

  localparam int AW = 32;
  localparam int LW = 11;
  localparam int WW = 16;
  localparam int NW = 12;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          go = 1'b0;
  logic          abort = 1'b0;
  logic          stall = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [WW-1:0] words_per_line = '0;
  logic [NW-1:0] num_lines = '0;
  logic [AW-1:0] line_stride = '0;
  logic          cmd;
  logic [AW-1:0] cmd_addr;
  logic          cmd_write_instead_of_read;
  logic          cmd_burst_instead_of_single_op;
  logic [LW-1:0] cmd_length_of_burst;
  logic          line_end;
  logic          busy;
  logic          done;

  alt_vipvfr120_prc_read_cmd_scheduler #(
    .ADDR_WIDTH(AW), .MAX_BURST_LENGTH_REQUIREDWIDTH(LW), .MAX_BURST(32),
    .WORD_BYTES(4), .WORDS_WIDTH(WW), .LINES_WIDTH(NW)
  ) u_dut (
    .clock(clock), .reset(reset), .go(go), .abort(abort),
    .base_addr(base_addr), .words_per_line(words_per_line),
    .num_lines(num_lines), .line_stride(line_stride), .stall(stall),
    .cmd(cmd), .cmd_addr(cmd_addr),
    .cmd_write_instead_of_read(cmd_write_instead_of_read),
    .cmd_burst_instead_of_single_op(cmd_burst_instead_of_single_op),
    .cmd_length_of_burst(cmd_length_of_burst),
    .line_end(line_end), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // accept / pulse log filled by the negedge monitor
  logic [31:0] acc_addr [64];
  int          acc_len  [64];
  logic        acc_burst[64];
  int          acc_cyc  [64];
  int          le_cyc   [64];
  int          n_acc = 0, n_le = 0, done_cyc = -1, go_cyc = 0, abort_cyc = -1;

  // hand-written expected command list for the current case
  logic [31:0] exp_addr[16];
  int          exp_len [16];
  int          exp_le  [16];

  always @(posedge clock) cyc <= cyc + 1;

  // Log accepted commands and output pulses mid-cycle
  always @(negedge clock) begin
    if (cmd && !stall && n_acc < 64) begin
      acc_addr[n_acc]  = cmd_addr;
      acc_len[n_acc]   = int'(cmd_length_of_burst);
      acc_burst[n_acc] = cmd_burst_instead_of_single_op;
      acc_cyc[n_acc]   = cyc;
      n_acc++;
    end
    if (line_end && n_le < 64) begin
      le_cyc[n_le] = cyc;
      n_le++;
    end
    if (done && done_cyc < 0) done_cyc = cyc;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic [31:0] a, input int l);
    exp_addr[i] = a;
    exp_len[i]  = l;
  endtask

  // 80 words/line, 2 lines, stride 0x200: 32+32+16 per line
  task automatic fill_case1(input logic [31:0] b);
    set_cmd(0, b + 32'h000, 32);
    set_cmd(1, b + 32'h080, 32);
    set_cmd(2, b + 32'h100, 16);
    set_cmd(3, b + 32'h200, 32);
    set_cmd(4, b + 32'h280, 32);
    set_cmd(5, b + 32'h300, 16);
    exp_le[0] = 2;
    exp_le[1] = 5;
  endtask

  task automatic run_frame(input logic [31:0] b, input int w, input int l, input logic [31:0] s,
                           input int stall_idx, input int stall_len, input int abort_idx,
                           input bit abort_stalled, input bit busy_go);
    int stall_cnt;
    n_acc = 0; n_le = 0; done_cyc = -1; abort_cyc = -1; stall_cnt = 0;
    base_addr = b; words_per_line = WW'(w); num_lines = NW'(l); line_stride = s;
    go = 1'b1; go_cyc = cyc;
    step();
    go = 1'b0;
    base_addr = 32'hDEAD_0000; words_per_line = 16'd5; num_lines = 12'd9; line_stride = 32'h10;
    for (int it = 0; it < 400 && done_cyc < 0; it++) begin
      stall = (n_acc == stall_idx) && (stall_cnt < stall_len);
      if (stall) stall_cnt++;
      abort = (n_acc == abort_idx) && (!abort_stalled || stall);
      if (abort && abort_cyc < 0) abort_cyc = cyc;
      if (stall && !abort) begin
        check_val("hold_cmd", {31'd0, cmd}, 32'd1);
        check_val("hold_addr", cmd_addr, exp_addr[stall_idx]);
        check_val("hold_len", 32'(cmd_length_of_burst), 32'(exp_len[stall_idx]));
      end
      go = busy_go && (it == 1);
      step();
    end
    go = 1'b0; stall = 1'b0; abort = 1'b0;
    check_val("frame_done_seen", {31'd0, done_cyc >= 0}, 32'd1);
    step();
    step();
    check_val("idle_busy", {31'd0, busy}, 32'd0);
    check_val("idle_cmd", {31'd0, cmd}, 32'd0);
  endtask

  task automatic verify(input string tag, input int n_exp, input int n_le_exp, input int exp_done);
    check_val({tag, "_ncmd"}, 32'(n_acc), 32'(n_exp));
    for (int i = 0; i < n_exp; i++) begin
      if (i < n_acc) begin
        check_val({tag, "_addr"}, acc_addr[i], exp_addr[i]);
        check_val({tag, "_len"}, 32'(acc_len[i]), 32'(exp_len[i]));
        check_val({tag, "_burst"}, {31'd0, acc_burst[i]}, {31'd0, exp_len[i] > 1});
      end
    end
    check_val({tag, "_nle"}, 32'(n_le), 32'(n_le_exp));
    for (int k = 0; k < n_le_exp; k++) begin
      if (k < n_le && exp_le[k] < n_acc) begin
        check_val({tag, "_le_cyc"}, 32'(le_cyc[k]), 32'(acc_cyc[exp_le[k]] + 1));
      end
    end
    check_val({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
  endtask

  initial begin
    step();
    step();
    check_val("rst_cmd", {31'd0, cmd}, 32'd0);
    check_val("rst_len", 32'(cmd_length_of_burst), 32'd0);
    check_val("rst_addr", cmd_addr, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_le", {31'd0, line_end}, 32'd0);
    reset = 1'b1;
    step();

    // 1: plain two-line frame, with an ignored go mid-frame
    fill_case1(32'h1000);
    run_frame(32'h1000, 80, 2, 32'h200, -1, 0, -1, 1'b0, 1'b1);
    verify("c1", 6, 2, acc_cyc[5] + 2);

    // 2: five-cycle stall on the second command
    run_frame(32'h1000, 80, 2, 32'h200, 1, 5, -1, 1'b0, 1'b0);
    verify("c2", 6, 2, acc_cyc[5] + 2);
    check_val("c2_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);

    // 3: single-word lines
    set_cmd(0, 32'h40, 1); set_cmd(1, 32'h44, 1); set_cmd(2, 32'h48, 1);
    exp_le[0] = 0; exp_le[1] = 1; exp_le[2] = 2;
    run_frame(32'h40, 1, 3, 32'h4, -1, 0, -1, 1'b0, 1'b0);
    verify("c3", 3, 3, acc_cyc[2] + 2);

    // burst boundary: 33 words split 32 + 1
    set_cmd(0, 32'h2000, 32); set_cmd(1, 32'h2080, 1);
    exp_le[0] = 1;
    run_frame(32'h2000, 33, 1, 32'h0, -1, 0, -1, 1'b0, 1'b0);
    verify("c3b", 2, 1, acc_cyc[1] + 2);

    // 4: zero-sized frames
    run_frame(32'h1000, 0, 2, 32'h200, -1, 0, -1, 1'b0, 1'b0);
    verify("c4w", 0, 0, go_cyc + 2);
    run_frame(32'h1000, 80, 0, 32'h200, -1, 0, -1, 1'b0, 1'b0);
    verify("c4l", 0, 0, go_cyc + 2);

    // 5: aborts
    fill_case1(32'h1000);
    exp_le[0] = 2;
    run_frame(32'h1000, 80, 2, 32'h200, 3, 3, 3, 1'b1, 1'b0);
    verify("c5s", 3, 1, abort_cyc + 2);
    run_frame(32'h1000, 80, 2, 32'h200, -1, 0, 3, 1'b0, 1'b0);
    verify("c5n", 4, 1, abort_cyc + 2);
    run_frame(32'h1000, 80, 2, 32'h200, -1, 0, 2, 1'b0, 1'b0);
    verify("c5e", 3, 1, abort_cyc + 2);

    // 6: reset mid-frame, then a fresh frame at 0x8000
    done_cyc = -1;
    base_addr = 32'h1000; words_per_line = 16'd80; num_lines = 12'd2; line_stride = 32'h200;
    go = 1'b1;
    step();
    go = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    check_val("c6_rst_cmd", {31'd0, cmd}, 32'd0);
    check_val("c6_rst_busy", {31'd0, busy}, 32'd0);
    check_val("c6_rst_addr", cmd_addr, 32'd0);
    step();
    step();
    check_val("c6_rst_len", 32'(cmd_length_of_burst), 32'd0);
    check_val("c6_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
    reset = 1'b1;
    step();
    fill_case1(32'h8000);
    run_frame(32'h8000, 80, 2, 32'h200, -1, 0, -1, 1'b0, 1'b0);
    verify("c6", 6, 2, acc_cyc[5] + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
